// File: rtl/stream_sink_fifo.sv
// ---------------------------------------------------------------------------
// stream_sink_fifo
//
// Receiving end of a valid-only stream. It takes words that arrive without
// any backpressure and offers them to a downstream consumer through a
// ready/valid handshake. A circular FIFO absorbs bursts. A word that arrives
// while the FIFO is full, and is not covered by a same-cycle pop, is dropped.
// Each drop sets the sticky overflow flag.
//
// Ports:
//   clk       in   system clock; all state updates on the rising edge
//   rst       in   asynchronous active-high reset
//   din       in   incoming word, sampled only when din_valid=1
//   din_valid in   incoming word valid (the upstream never stalls)
//   m_data    out  head-of-FIFO word (first-word fall-through)
//   m_valid   out  FIFO non-empty
//   m_ready   in   consumer accepts the head word when m_valid=1
//   count     out  words currently stored, 0..DEPTH
//   full      out  count==DEPTH
//   overflow  out  sticky flag: at least one word has been dropped
//   ovf_clr   in   synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module stream_sink_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wrPtr_q, wrPtr_d;
  logic [AW-1:0]         rdPtr_q, rdPtr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, drop;

  // The FIFO tracks fullness and emptiness through the occupancy counter
  // alone. Pointer equality cannot tell full from empty, so it is not used.
  assign m_valid  = (count_q != '0);
  assign full     = (count_q == FullCount);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign m_data   = mem_q[rdPtr_q];

  // A pop frees a slot in the same cycle. A word that arrives while the FIFO
  // is full can therefore still be written when the consumer takes the head.
  assign pop  = m_valid & m_ready;
  assign push = din_valid & (~full | pop);
  assign drop = din_valid & full & ~pop;

  // Next-state logic for the pointers, the occupancy count and the sticky
  // overflow flag. Pointers wrap naturally because they are exactly AW bits.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as a clear wins, so the lost word is not hidden.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Control state. Reset discards every stored word immediately, so m_valid
  // falls together with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The storage array has no reset. Stale contents are never visible, because
  // m_valid gates them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= din;
    end
  end

endmodule

// File: tb/tb_stream_sink_fifo.sv
// ---------------------------------------------------------------------------
// tb_stream_sink_fifo
//
// Directed bench for stream_sink_fifo with DATA_WIDTH=32 and DEPTH=16.
// Short handshake cases come from a table of {inputs, expected outputs}
// records. The multi-cycle cases are written out as sequences: fill/overflow,
// push+pop at full, wrap-around streaming, the overflow-clear race, and an
// asynchronous reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_stream_sink_fifo;

  localparam int DW = 32;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    count;
  logic          full;
  logic          overflow;
  logic          ovf_clr;

  int testsRun  = 0;
  int testsFail = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] din;
    logic        dinValid;
    logic        mReady;
    logic        ovfClr;
    logic        expValid;
    logic [31:0] expData;
    logic [4:0]  expCount;
    logic        expFull;
    logic        expOvf;
  } vec_t;

  vec_t vecs[$];

  stream_sink_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the rising edge happen, and return 1 ns
  // later. Outputs are then settled and can be sampled safely.
  task automatic applyStimulus(input logic r, input logic [31:0] d,
                               input logic dv, input logic mr, input logic oc);
    rst       = r;
    din       = d;
    din_valid = dv;
    m_ready   = mr;
    ovf_clr   = oc;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value and log it.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Write DP words starting at value base, with the consumer stalled.
  task automatic fillFifo(input logic [31:0] base);
    for (int i = 0; i < DP; i++) begin
      applyStimulus(1'b0, base + 32'(i), 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;

    // ---------------- table-driven handshake cases ----------------
    //            name          rst din           dv  mr  oc   val data          cnt full ovf
    vecs.push_back('{"rst0",    1, 32'hDEADBEEF, 1,  0,  0,   0, 32'h0,          0,  0,  0});
    vecs.push_back('{"rst1",    1, 32'hDEADBEEF, 1,  0,  0,   0, 32'h0,          0,  0,  0});
    vecs.push_back('{"rst2",    1, 32'hDEADBEEF, 1,  0,  0,   0, 32'h0,          0,  0,  0});
    vecs.push_back('{"release", 0, 32'hDEADBEEF, 0,  0,  0,   0, 32'h0,          0,  0,  0});
    vecs.push_back('{"single",  0, 32'h000000A5, 1,  0,  0,   1, 32'h000000A5,   1,  0,  0});
    vecs.push_back('{"sglpop",  0, 32'h0,        0,  1,  0,   0, 32'h0,          0,  0,  0});
    vecs.push_back('{"emptyrw", 0, 32'h11,       1,  1,  0,   1, 32'h11,         1,  0,  0});
    vecs.push_back('{"pushpop", 0, 32'h22,       1,  1,  0,   1, 32'h22,         1,  0,  0});
    vecs.push_back('{"hold",    0, 32'h33,       0,  0,  1,   1, 32'h22,         1,  0,  0});
    vecs.push_back('{"drain",   0, 32'h0,        0,  1,  0,   0, 32'h0,          0,  0,  0});
    vecs.push_back('{"idlerdy", 0, 32'h44,       0,  1,  0,   0, 32'h0,          0,  0,  0});

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].dinValid,
                    vecs[i].mReady, vecs[i].ovfClr);
      checkOutput({vecs[i].name, ".valid"}, 32'(m_valid),  32'(vecs[i].expValid));
      checkOutput({vecs[i].name, ".count"}, 32'(count),    32'(vecs[i].expCount));
      checkOutput({vecs[i].name, ".full"},  32'(full),     32'(vecs[i].expFull));
      checkOutput({vecs[i].name, ".ovf"},   32'(overflow), 32'(vecs[i].expOvf));
      if (vecs[i].expValid) begin
        checkOutput({vecs[i].name, ".data"}, m_data, vecs[i].expData);
      end
    end

    // ---------------- fill to full, overflow, drain ----------------
    for (int i = 1; i <= DP; i++) begin
      applyStimulus(1'b0, 32'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("fill.count", 32'(count), 32'(i));
    end
    checkOutput("fill.full", 32'(full), 32'd1);
    checkOutput("fill.ovf0", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 32'd17, 1'b1, 1'b0, 1'b0);
    checkOutput("ovf.flag",  32'(overflow), 32'd1);
    checkOutput("ovf.count", 32'(count), 32'd16);
    for (int k = 1; k <= DP; k++) begin
      checkOutput("drain.valid", 32'(m_valid), 32'd1);
      checkOutput("drain.data", m_data, 32'(k));
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("drain.empty", 32'(m_valid), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr.ovf", 32'(overflow), 32'd0);

    // ---------------- simultaneous push/pop at full ----------------
    fillFifo(32'd201);
    checkOutput("pp.prefull", 32'(full), 32'd1);
    applyStimulus(1'b0, 32'd100, 1'b1, 1'b1, 1'b0);
    checkOutput("pp.count", 32'(count), 32'd16);
    checkOutput("pp.ovf",   32'(overflow), 32'd0);
    checkOutput("pp.head",  m_data, 32'd202);
    for (int k = 0; k < DP; k++) begin
      checkOutput("pp.data", m_data, (k == DP-1) ? 32'd100 : 32'(202 + k));
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("pp.empty", 32'(m_valid), 32'd0);

    // ---------------- wrap-around streaming ----------------
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 32'(i), 1'b1, 1'b1, 1'b0);
      checkOutput("wrap.data",  m_data, 32'(i));
      checkOutput("wrap.count", 32'(count), 32'd1);
      checkOutput("wrap.ovf",   32'(overflow), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap.empty", 32'(count), 32'd0);

    // ---------------- overflow clear race ----------------
    fillFifo(32'd300);
    applyStimulus(1'b0, 32'd999, 1'b1, 1'b0, 1'b0);
    checkOutput("race.set", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 32'd998, 1'b1, 1'b0, 1'b1);
    checkOutput("race.dropwins", 32'(overflow), 32'd1);
    checkOutput("race.count", 32'(count), 32'd16);
    checkOutput("race.head", m_data, 32'd300);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("race.clr", 32'(overflow), 32'd0);

    // ---------------- asynchronous reset mid-operation ----------------
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst.valid", 32'(m_valid), 32'd0);
    checkOutput("arst.count", 32'(count), 32'd0);
    checkOutput("arst.full",  32'(full), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("arst.after", 32'(m_valid), 32'd0);
    applyStimulus(1'b0, 32'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("arst.first", m_data, 32'h55);
    checkOutput("arst.cnt1", 32'(count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/stream_sink_fifo.md
Name: stream_sink_fifo

Overview:
- Receiving end of the valid-only delay pipeline stream.
- Accepts a stream that has no backpressure (`din`/`din_valid`, one word per valid cycle) and re-presents it as a ready/valid handshake to a downstream consumer.
- Absorbs bursts in a circular FIFO; words that arrive when the FIFO is full are dropped and flagged.
- Sits between a delay pipeline output and any consumer that may stall.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- DEPTH, 16, FIFO capacity in words; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  incoming data word; sampled only when din_valid=1.
- din_valid  input  1  incoming word valid; no ready, upstream never stalls.
- m_data  output  DATA_WIDTH  head-of-FIFO word; don't-care while m_valid=0.
- m_valid  output  1  FIFO non-empty; m_data is valid.
- m_ready  input  1  consumer accepts head word when m_valid=1.
- count  output  AW+1  number of words currently stored, 0..DEPTH.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky flag: at least one word has been dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst=1, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, m_valid=0, full=0, overflow=0.
  - Storage array is not cleared.
- Derived signals:
  - pop = m_valid & m_ready.
  - push = din_valid & (!full | pop).
  - drop = din_valid & full & !pop.
- Write:
  - On push, mem[wr_ptr] <= din and wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - din is ignored when din_valid=0.
- Read:
  - Head word is read combinationally from mem[rd_ptr] (first-word fall-through).
  - On pop, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop together, or neither: unchanged.
- Outputs: m_valid = (count!=0) and full = (count==DEPTH), both derived from registered count.
- Latency: a word written at edge N is visible on m_data with m_valid=1 in the cycle after edge N. There is no combinational path from din to m_data.
- Empty FIFO with din_valid=1 and m_ready=1: no pop this cycle because m_valid=0. The word is stored, and pop becomes possible on the next cycle.
- Full FIFO with din_valid=1 and pop=1: the write is accepted into the slot freed by the pop. count stays DEPTH and nothing is dropped.
- Full FIFO with din_valid=1 and no pop: the word is discarded, pointers and count are unchanged, and overflow <= 1.
- Overflow flag:
  - ovf_clr=1 clears overflow on the next edge.
  - If drop and ovf_clr occur in the same cycle, drop wins and overflow stays 1.
- Pointer wrap: pointers wrap DEPTH-1 -> 0 silently. Full and empty are distinguished by count, never by pointer equality.
- m_ready while m_valid=0: no effect.
- Reset mid-operation: all stored words are discarded immediately. m_valid falls asynchronously with rst.
- Data ordering: strict FIFO order. Every accepted word is delivered exactly once, with no duplication or reordering.

Test Plan:
- Reset sanity:
  - Assert rst for 3 cycles with din_valid=1 and din=32'hDEAD_BEEF.
  - Required: m_valid=0, count=0, full=0 and overflow=0 throughout reset.
  - Required: first word appears only after release.
- Single word:
  - With m_ready=0, pulse din_valid with din=32'h0000_00A5.
  - Required: next cycle m_valid=1, m_data=32'h0000_00A5, count=1.
  - Raise m_ready for 1 cycle. Required: m_valid=0 and count=0 after the edge.
- Fill to full and overflow (DEPTH=16):
  - With m_ready=0, write values 1..17 on consecutive cycles.
  - Required: full=1 after the 16th write, and count=16.
  - Required: overflow=1 after the 17th write.
  - Drain with m_ready=1. Required: reads return 1..16 in order; 17 never appears.
- Simultaneous push/pop at full:
  - With 16 words stored, assert din_valid (din=100) and m_ready for 1 cycle.
  - Required: count stays 16 and overflow stays 0.
  - Required: the head advances, and the last word drained is 100.
- Wrap-around streaming:
  - Run 40 consecutive writes (0..39) with m_ready held at 1.
  - Required: every value is received once, in order.
  - Required: count never exceeds 1 and overflow=0.
- Overflow clear race:
  - With overflow=1 and the FIFO full, assert ovf_clr in the same cycle as a drop. Required: overflow remains 1.
  - Then assert ovf_clr alone. Required: overflow=0 on the next cycle.
